lock_controller: RTL and testbench

Code-entry state machine for the digital lock, sitting directly upstream of `blinker`. It accepts keypad digits, compares a completed entry against the stored code and holds the lock open for a fixed time on a match. When unlocked it also accepts a new code. It drives `blinker`'s `start_blinking`/`blinkType` handshake: error pattern (type 0) on mismatch or timeout, success pattern (type 1) after reprogramming.

---
 rtl/lock_controller_if.sv | 23 ++
 rtl/lock_controller.sv | 142 ++++++++++++++
 tb/tb_lock_controller.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_controller_if.sv
// rtl/lock_controller_if.sv - keypad, blinker handshake and status signals of lock_controller
interface lock_controller_if #(
    parameter int DIGIT_W = 4
);
    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               prog_req;
    logic               done_blinking;
    logic               start_blinking;
    logic               blinkType;
    logic               unlocked;
    logic               busy;

    modport master (
        output digit_valid, digit, prog_req, done_blinking,
        input  start_blinking, blinkType, unlocked, busy
    );

    modport slave (
        input  digit_valid, digit, prog_req, done_blinking,
        output start_blinking, blinkType, unlocked, busy
    );
endinterface

// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - code-entry FSM for the digital lock, drives the blinker start/type handshake
module lock_controller #(
    parameter int                          CODE_LEN      = 4,
    parameter int                          DIGIT_W       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE  = 16'h1234,
    parameter logic [31:0]                 UNLOCK_CYCLES = 32'd60000000,
    parameter logic [31:0]                 ENTRY_TIMEOUT = 32'd120000000
) (
    input  logic             hwclk,
    input  logic             rst_n,
    lock_controller_if.slave lock
);
    localparam int              CODE_W     = CODE_LEN * DIGIT_W;
    localparam int              CNT_W      = $clog2(CODE_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(CODE_LEN - 1);
    // blinker clears done late, so the first two HOLD cycles never look at it
    localparam logic [31:0]     HOLD_BLIND = 32'd2;

    typedef enum logic [2:0] {
        S_LOCKED,
        S_CHECK,
        S_UNLOCKED,
        S_PROG,
        S_BLINK_ARM,
        S_BLINK_HOLD
    } state_t;

    state_t             state;
    state_t             ret;
    logic [CODE_W-1:0]  entry;
    logic [CODE_W-1:0]  code;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        timer;
    logic               prog_mode;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_LOCKED;
            ret                 <= S_LOCKED;
            code                <= DEFAULT_CODE;
            entry               <= '0;
            cnt                 <= '0;
            timer               <= '0;
            prog_mode           <= 1'b0;
            lock.start_blinking <= 1'b0;
            lock.blinkType      <= 1'b0;
            lock.unlocked       <= 1'b0;
            lock.busy           <= 1'b0;
        end else begin
            case (state)
                S_LOCKED, S_PROG: begin
                    if (lock.digit_valid) begin
                        entry <= (entry << DIGIT_W) | CODE_W'(lock.digit);
                        timer <= '0;
                        if (cnt == LAST_DIGIT) begin
                            cnt       <= '0;
                            state     <= S_CHECK;
                            lock.busy <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (cnt != '0) begin
                        if (timer == ENTRY_TIMEOUT - 32'd1) begin
                            cnt            <= '0;
                            entry          <= '0;
                            timer          <= '0;
                            prog_mode      <= 1'b0;
                            ret            <= S_LOCKED;
                            lock.blinkType <= 1'b0;
                            lock.busy      <= 1'b1;
                            state          <= S_BLINK_ARM;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                end

                S_CHECK: begin
                    entry <= '0;
                    if (prog_mode) begin
                        code           <= entry;
                        prog_mode      <= 1'b0;
                        ret            <= S_LOCKED;
                        lock.blinkType <= 1'b1;
                        state          <= S_BLINK_ARM;
                    end else if (entry == code) begin
                        timer         <= '0;
                        lock.unlocked <= 1'b1;
                        lock.busy     <= 1'b0;
                        state         <= S_UNLOCKED;
                    end else begin
                        ret            <= S_LOCKED;
                        lock.blinkType <= 1'b0;
                        state          <= S_BLINK_ARM;
                    end
                end

                S_UNLOCKED: begin
                    // a reprogram request beats the hold-time expiry in the same cycle
                    if (lock.prog_req) begin
                        cnt           <= '0;
                        entry         <= '0;
                        timer         <= '0;
                        prog_mode     <= 1'b1;
                        lock.unlocked <= 1'b0;
                        state         <= S_PROG;
                    end else if (timer == UNLOCK_CYCLES - 32'd1) begin
                        timer         <= '0;
                        lock.unlocked <= 1'b0;
                        state         <= S_LOCKED;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                S_BLINK_ARM: begin
                    timer               <= '0;
                    lock.start_blinking <= 1'b1;
                    state               <= S_BLINK_HOLD;
                end

                S_BLINK_HOLD: begin
                    if (timer < HOLD_BLIND) begin
                        timer <= timer + 32'd1;
                    end else if (lock.done_blinking) begin
                        timer               <= '0;
                        lock.start_blinking <= 1'b0;
                        lock.busy           <= 1'b0;
                        state               <= ret;
                    end
                end

                default: begin
                    state               <= S_LOCKED;
                    lock.start_blinking <= 1'b0;
                    lock.unlocked       <= 1'b0;
                    lock.busy           <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lock_controller.sv
// tb/tb_lock_controller.sv - self-checking bench for lock_controller with a behavioural blinker
module tb_lock_controller;
    localparam int U         = 20;
    localparam int T         = 50;
    localparam int BLINK_LAT = 10;
    localparam int FALL      = (BLINK_LAT > 3) ? BLINK_LAT : 3;

    logic hwclk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   k        = 0;

    lock_controller_if #(.DIGIT_W(4)) lif();

    lock_controller #(
        .CODE_LEN     (4),
        .DIGIT_W      (4),
        .DEFAULT_CODE (16'h1234),
        .UNLOCK_CYCLES(32'd20),
        .ENTRY_TIMEOUT(32'd50)
    ) dut (
        .hwclk(hwclk),
        .rst_n(rst_n),
        .lock (lif)
    );

    always #5 hwclk = ~hwclk;

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, k);
    endtask

    task automatic checkn(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, k);
    endtask

    // Model: outputs are windows of cycle numbers [lo, hi) scheduled when an entry completes
    int          busy_lo, busy_hi, unl_lo, unl_hi, st_lo, st_hi, bt_at, ndig, last_dig;
    logic        bt_new, bt_old, m_prog;
    logic [15:0] m_code, m_entry;

    function automatic logic in_win(input int c, input int lo, input int hi);
        return (c >= lo) && (c < hi);
    endfunction

    task automatic model_reset();
        busy_lo = 0; busy_hi = 0; unl_lo = 0; unl_hi = 0; st_lo = 0; st_hi = 0;
        bt_at = 0; bt_new = 1'b0; bt_old = 1'b0;
        ndig = 0; last_dig = 0; m_prog = 1'b0;
        m_code = 16'h1234; m_entry = 16'h0000;
    endtask

    task automatic model_blink(input int a, input logic ty);
        st_lo   = a + 1;
        st_hi   = a + 1 + FALL;
        busy_hi = a + 1 + FALL;
        bt_old  = bt_new;
        bt_new  = ty;
        bt_at   = a;
    endtask

    task automatic model_step();
        if (in_win(k - 1, unl_lo, unl_hi)) begin
            if (lif.prog_req) begin
                unl_hi = k;
                m_prog = 1'b1;
                ndig   = 0;
            end
        end else if (!in_win(k - 1, busy_lo, busy_hi)) begin
            if (lif.digit_valid) begin
                m_entry  = {m_entry[11:0], lif.digit};
                ndig++;
                last_dig = k;
                if (ndig == 4) begin
                    ndig    = 0;
                    busy_lo = k;
                    if (m_prog) begin
                        m_code = m_entry;
                        m_prog = 1'b0;
                        model_blink(k + 1, 1'b1);
                    end else if (m_entry == m_code) begin
                        busy_hi = k + 1;
                        unl_lo  = k + 1;
                        unl_hi  = k + 1 + U;
                    end else begin
                        model_blink(k + 1, 1'b0);
                    end
                end
            end else if (ndig > 0 && k == last_dig + T) begin
                ndig    = 0;
                m_prog  = 1'b0;
                busy_lo = k;
                model_blink(k, 1'b0);
            end
        end
    endtask

    always @(posedge hwclk) begin
        k++;
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge hwclk) begin
        if (k >= 1) begin
            check1("cyc_unlocked", lif.unlocked,       rst_n && in_win(k, unl_lo, unl_hi));
            check1("cyc_busy",     lif.busy,           rst_n && in_win(k, busy_lo, busy_hi));
            check1("cyc_start",    lif.start_blinking, rst_n && in_win(k, st_lo, st_hi));
            check1("cyc_type",     lif.blinkType,      rst_n && ((k >= bt_at) ? bt_new : bt_old));
        end
    end

    // Blinker: done stays stale for 2 edges after a start rise, then low, then high BLINK_LAT edges after it
    int   bk = 0;
    int   rise_k = 0;
    int   blk_d;
    logic seen = 1'b0;
    logic stale = 1'b1;
    logic prev_start = 1'b0;

    always @(posedge hwclk) bk++;

    always @(negedge hwclk) begin
        if (lif.start_blinking && !prev_start) begin
            stale  = lif.done_blinking;
            rise_k = bk;
            seen   = 1'b1;
        end
        prev_start = lif.start_blinking;
        blk_d      = bk + 1 - rise_k;
        lif.done_blinking = !seen ? 1'b1 : ((blk_d <= 2) ? stale : (blk_d >= BLINK_LAT));
    end

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        lif.digit_valid = 1'b1;
        lif.digit       = d;
        tick();
        lif.digit_valid = 1'b0;
        lif.digit       = 4'h0;
    endtask

    task automatic enter(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
    endtask

    int cnt_hi, cnt_st;

    initial begin
        lif.digit_valid = 1'b0;
        lif.digit       = 4'h0;
        lif.prog_req    = 1'b0;
        rst_n           = 1'b0;
        repeat (3) tick();
        check1("rst_unlocked", lif.unlocked, 1'b0);
        check1("rst_start", lif.start_blinking, 1'b0);
        check1("rst_busy", lif.busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        // correct code
        enter(16'h1234);
        check1("ok_busy_in_check", lif.busy, 1'b1);
        check1("ok_not_yet_unlocked", lif.unlocked, 1'b0);
        tick();
        check1("ok_unlocked_rise", lif.unlocked, 1'b1);
        cnt_hi = 1; cnt_st = 0;
        repeat (25) begin
            tick();
            cnt_hi += int'(lif.unlocked);
            cnt_st += int'(lif.start_blinking);
        end
        checkn("ok_unlock_len", cnt_hi, 20);
        checkn("ok_no_blink", cnt_st, 0);

        // wrong code, then the right one
        enter(16'h1235);
        check1("bad_check_start_low", lif.start_blinking, 1'b0);
        tick();
        check1("bad_type_error", lif.blinkType, 1'b0);
        check1("bad_arm_start_low", lif.start_blinking, 1'b0);
        tick();
        check1("bad_start_rise", lif.start_blinking, 1'b1);
        cnt_st = 1; cnt_hi = 0;
        repeat (14) begin
            tick();
            cnt_st += int'(lif.start_blinking);
            cnt_hi += int'(lif.unlocked);
        end
        checkn("bad_start_len", cnt_st, 10);
        checkn("bad_no_unlock", cnt_hi, 0);
        enter(16'h1234);
        tick();
        check1("bad_retry_unlock", lif.unlocked, 1'b1);
        repeat (22) tick();

        // reprogram to 9876
        enter(16'h1234);
        tick();
        check1("prog_pre_unlock", lif.unlocked, 1'b1);
        repeat (2) tick();
        lif.prog_req = 1'b1;
        tick();
        lif.prog_req = 1'b0;
        check1("prog_relock", lif.unlocked, 1'b0);
        check1("prog_not_busy", lif.busy, 1'b0);
        enter(16'h9876);
        tick();
        check1("prog_type_success", lif.blinkType, 1'b1);
        tick();
        check1("prog_start_rise", lif.start_blinking, 1'b1);
        repeat (12) tick();
        checkn("prog_model_code", int'(m_code), 32'h9876);
        check1("prog_idle_after", lif.busy, 1'b0);
        enter(16'h1234);
        tick();
        check1("prog_old_code_type", lif.blinkType, 1'b0);
        tick();
        check1("prog_old_code_start", lif.start_blinking, 1'b1);
        repeat (12) tick();
        enter(16'h9876);
        tick();
        check1("prog_new_code_unlock", lif.unlocked, 1'b1);
        repeat (22) tick();

        // entry timeout after two digits (code is 9876)
        press(4'h9);
        press(4'h8);
        repeat (49) tick();
        check1("to_before", lif.busy, 1'b0);
        tick();
        check1("to_fired_busy", lif.busy, 1'b1);
        check1("to_fired_type", lif.blinkType, 1'b0);
        tick();
        check1("to_start_rise", lif.start_blinking, 1'b1);
        repeat (12) tick();
        enter(16'h9876);
        tick();
        check1("to_cnt_cleared_unlock", lif.unlocked, 1'b1);

        // prog_req on the expiry cycle wins
        repeat (19) tick();
        check1("exp_last_unlocked_cycle", lif.unlocked, 1'b1);
        lif.prog_req = 1'b1;
        tick();
        lif.prog_req = 1'b0;
        check1("exp_relocked", lif.unlocked, 1'b0);
        enter(16'h5555);
        tick();
        check1("exp_prog_won_type", lif.blinkType, 1'b1);
        repeat (13) tick();

        // strobes during BLINK_HOLD are dropped
        enter(16'h0000);
        repeat (2) tick();
        press(4'h5);
        press(4'h5);
        press(4'h5);
        repeat (10) tick();
        enter(16'h5555);
        tick();
        check1("hold_strobes_ignored", lif.unlocked, 1'b1);
        repeat (22) tick();

        // reset in the middle of a blink
        enter(16'h1111);
        repeat (3) tick();
        check1("rstmid_pre_start", lif.start_blinking, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("rstmid_start_drop", lif.start_blinking, 1'b0);
        check1("rstmid_busy_drop", lif.busy, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        enter(16'h1234);
        tick();
        check1("rstmid_default_code", lif.unlocked, 1'b1);
        repeat (22) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", k);
        $fatal(1, "watchdog");
    end
endmodule
